// File: rtl/screen_init.sv
// Screen initialiser: clears the whole frame to CLEAR_COLOUR in raster
// order, then starts the grid drawer and forwards its pixel stream to the
// VGA adapter until the drawer reports completion.
module screen_init #(
  parameter int          SCREEN_W     = 320,
  parameter int          SCREEN_H     = 240,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       done,
  output logic       grid_start,
  input  logic       grid_done,
  input  logic [8:0] grid_x,
  input  logic [7:0] grid_y,
  input  logic [2:0] grid_colour,
  input  logic       grid_plot,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  // Counter widths cover SCREEN_W-1 / SCREEN_H-1; at least one bit each.
  localparam int XW = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
  localparam int YW = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_H - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    GRID_ARM = 3'd2,
    GRID_RUN = 3'd3,
    FIN      = 3'd4
  } state_t;

  state_t        state, nxt;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic          last_px;

  assign last_px = (cx == X_LAST) && (cy == Y_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic plus state-decoded handshake outputs. done and
  // grid_start are pure decodes of the state register, so they are glitch
  // free and drop together with the state change.
  always_comb begin
    nxt        = state;
    done       = 1'b0;
    grid_start = 1'b0;
    case (state)
      IDLE:     if (start) nxt = CLEAR;
      CLEAR:    if (last_px) nxt = GRID_ARM;
      GRID_ARM: begin
        grid_start = 1'b1;
        // A grid_done left high by an earlier run must be seen low first.
        if (!grid_done) nxt = GRID_RUN;
      end
      GRID_RUN: begin
        grid_start = 1'b1;
        if (grid_done) nxt = FIN;
      end
      FIN: begin
        done = 1'b1;
        if (start) nxt = CLEAR;
      end
      default:  nxt = IDLE;
    endcase
  end

  // Raster counters and registered pixel stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx         <= '0;
      cy         <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          vga_x      <= 9'(cx);
          vga_y      <= 8'(cy);
          vga_colour <= CLEAR_COLOUR;
          vga_plot   <= 1'b1;
          if (cx == X_LAST) begin
            cx <= '0;
            cy <= (cy == Y_LAST) ? '0 : cy + 1'b1;
          end else begin
            cx <= cx + 1'b1;
          end
        end
        GRID_RUN: begin
          if (grid_done) begin
            vga_plot <= 1'b0;
          end else begin
            vga_x      <= grid_x;
            vga_y      <= grid_y;
            vga_colour <= grid_colour;
            vga_plot   <= grid_plot;
          end
        end
        IDLE, FIN: begin
          vga_plot <= 1'b0;
          if (start) begin
            cx <= '0;
            cy <= '0;
          end
        end
        default: vga_plot <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_screen_init.sv
// Scoreboard bench for screen_init on a 4x3 screen: stimulus pushes the
// expected pixels, a monitor pops one per emitted vga_plot cycle.
module tb_screen_init;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       done, grid_start;
  logic       grid_done = 1'b0;
  logic [8:0] grid_x = '0;
  logic [7:0] grid_y = '0;
  logic [2:0] grid_colour = '0;
  logic       grid_plot = 1'b0;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } px_t;

  px_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  screen_init #(.SCREEN_W(4), .SCREEN_H(3), .CLEAR_COLOUR(3'b000)) dut (
    .clk(clk), .rst(rst), .start(start), .done(done),
    .grid_start(grid_start), .grid_done(grid_done),
    .grid_x(grid_x), .grid_y(grid_y), .grid_colour(grid_colour),
    .grid_plot(grid_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Advance one clock; inputs and checks happen 2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_clear(input int n);
    for (int i = 0; i < n; i++) begin
      px_t p;
      p.x = 9'(i % 4);
      p.y = 8'(i / 4);
      p.c = 3'b000;
      exp_q.push_back(p);
    end
  endtask

  // Monitor: every plotted pixel must match the head of the scoreboard.
  always @(posedge clk) begin
    #1;
    if (!rst && vga_plot === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_plot: got (%0d,%0d,%0b) expected no plot",
                 vga_x, vga_y, vga_colour);
      end else begin
        px_t e;
        e = exp_q.pop_front();
        if (vga_x !== e.x || vga_y !== e.y || vga_colour !== e.c) begin
          errors++;
          $display("FAIL pixel: got (%0d,%0d,%0b) expected (%0d,%0d,%0b)",
                   vga_x, vga_y, vga_colour, e.x, e.y, e.c);
        end
      end
    end
  end

  initial begin
    // Async reset with junk on the grid inputs, checked before any clock edge.
    grid_x = 9'd123; grid_y = 8'd77; grid_colour = 3'b101; grid_plot = 1'b1;
    #3 rst = 1'b1;
    #1;
    chk("rst_done", 32'(done), 0);
    chk("rst_grid_start", 32'(grid_start), 0);
    chk("rst_plot", 32'(vga_plot), 0);
    chk("rst_xyc", {vga_x, vga_y, vga_colour}, 0);
    step(); step();
    rst = 1'b0;
    step(); step();
    chk("idle_no_done", 32'(done), 0);

    // Full clear; stale grid_done high; extra start mid-clear is ignored.
    grid_plot = 1'b0;
    grid_done = 1'b1;
    push_clear(12);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("first_latency_plot", 32'(vga_plot), 0);
    for (int i = 1; i <= 12; i++) begin
      if (i == 6) start = 1'b1;
      step();
      start = 1'b0;
      if (i == 11) chk("grid_start_during_clear", 32'(grid_start), 0);
    end
    chk("grid_start_after_clear", 32'(grid_start), 1);
    chk("clear_drained", 32'(exp_q.size()), 0);

    // GRID_ARM with stale grid_done: hold three cycles, junk must not leak.
    grid_x = 9'd17; grid_y = 8'd9; grid_colour = 3'b010; grid_plot = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("arm_plot", 32'(vga_plot), 0);
      chk("arm_grid_start", 32'(grid_start), 1);
      chk("arm_done", 32'(done), 0);
    end
    grid_done = 1'b0;
    grid_plot = 1'b0;
    step();
    chk("run_grid_start", 32'(grid_start), 1);

    // Forward one grid pixel with one cycle of latency.
    grid_x = 9'd90; grid_y = 8'd40; grid_colour = 3'b111; grid_plot = 1'b1;
    exp_q.push_back('{x: 9'd90, y: 8'd40, c: 3'b111});
    chk("fwd_not_yet", 32'(vga_plot), 0);
    step();
    grid_plot = 1'b0;
    chk("fwd_drained", 32'(exp_q.size()), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("run_done_low", 32'(done), 0);
    chk("run_plot_low", 32'(vga_plot), 0);
    grid_done = 1'b1;
    step();
    chk("fin_done", 32'(done), 1);
    chk("fin_grid_start", 32'(grid_start), 0);
    chk("fin_plot", 32'(vga_plot), 0);
    step();
    chk("fin_done_hold", 32'(done), 1);

    // Restart from FIN; reset lands on clear pixel (2,1).
    push_clear(7);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_done_cleared", 32'(done), 0);
    for (int i = 1; i <= 7; i++) step();
    chk("restart_drained", 32'(exp_q.size()), 0);
    chk("at_2_1", {vga_x, vga_y}, {9'd2, 8'd1});
    rst = 1'b1;
    #1;
    chk("midrst_plot", 32'(vga_plot), 0);
    chk("midrst_xyc", {vga_x, vga_y, vga_colour}, 0);
    chk("midrst_grid_start", 32'(grid_start), 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) step();
    chk("post_rst_done", 32'(done), 0);
    chk("post_rst_grid_start", 32'(grid_start), 0);
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/screen_init.md
SCREEN_INIT -- requirements
Module: screen_init

Interface
REQ-001 Parameter SCREEN_W, default 320, meaning pixels per row cleared.
REQ-002 Parameter SCREEN_H, default 240, meaning rows cleared.
REQ-003 Parameter CLEAR_COLOUR, default 3'b000, meaning colour written during clear.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous reset, active-high.
REQ-006 start  input  1  request a full clear-then-grid sequence.
REQ-007 done  output  1  high when the sequence has completed.
REQ-008 grid_start  output  1  start request to the downstream grid drawer.
REQ-009 grid_done  input  1  grid drawer completion flag; stays high until that drawer is restarted.
REQ-010 grid_x  input  9, grid_y  input  8, grid_colour  input  3, grid_plot  input  1: grid drawer pixel stream.
REQ-011 vga_x  output  9, vga_y  output  8, vga_colour  output  3, vga_plot  output  1: pixel stream to the VGA adapter, all registered.

Function
REQ-012 The FSM SHALL have states IDLE, CLEAR, GRID_ARM, GRID_RUN and FIN.
REQ-013 IDLE: on start=1, the FSM SHALL go to CLEAR with internal counters cx=0, cy=0; start=0 keeps IDLE.
REQ-014 CLEAR SHALL emit one pixel per cycle in raster order, x fastest: vga_x=cx, vga_y=cy, vga_colour=CLEAR_COLOUR, vga_plot=1.
REQ-015 The first clear pixel (0,0) SHALL appear on the outputs at the clock edge after the one at which start was sampled.
REQ-016 Wrap rules: cx=SCREEN_W-1 wraps to 0 and increments cy; pixel (SCREEN_W-1,SCREEN_H-1) is the last pixel, and the FSM SHALL then go to GRID_ARM; exactly SCREEN_W*SCREEN_H plot cycles.
REQ-017 Counters SHALL be wide enough for SCREEN_W-1 and SCREEN_H-1 without overflow; vga_x/vga_y are the zero-extended counter values.
REQ-018 GRID_ARM SHALL hold grid_start=1 and vga_plot=0, and go to GRID_RUN only after sampling grid_done=0; a stale high grid_done from a previous run is ignored.
REQ-019 GRID_RUN SHALL hold grid_start=1 and forward grid_x/grid_y/grid_colour/grid_plot to vga_* with exactly one cycle of register latency.
REQ-020 In GRID_RUN, sampling grid_done=1 SHALL drive grid_start=0, vga_plot=0 on the next edge, and go to FIN.
REQ-021 FIN SHALL drive done=1 and vga_plot=0; on start=1, the FSM SHALL clear done and go to CLEAR with counters zeroed (restart without passing IDLE).
REQ-022 done SHALL be 0 in every state except FIN.
REQ-023 start SHALL be ignored in CLEAR, GRID_ARM and GRID_RUN.
REQ-024 vga_plot SHALL be 0 in IDLE, GRID_ARM and FIN.
REQ-025 grid_start SHALL be 0 in IDLE, CLEAR and FIN.
REQ-026 grid_* inputs SHALL have no effect on vga_* outside GRID_RUN.

Reset
REQ-027 rst=1 SHALL immediately, without a clock edge, force state IDLE, done=0, grid_start=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, and counters to 0.
REQ-028 Reset asserted mid-CLEAR or mid-GRID SHALL abandon the sequence; after rst falls, nothing is emitted until a new start.

Verification (SCREEN_W=4, SCREEN_H=3)
REQ-029 Test: start pulse in IDLE -> 12 consecutive vga_plot=1 cycles, (0,0),(1,0),(2,0),(3,0),(0,1)...(3,2), colour 000, then grid_start=1.
REQ-030 Test: grid_done held 1 on entering GRID_ARM, drop it 3 cycles later, raise it 5 cycles after that -> FSM stays in GRID_ARM until the drop, done=1 only after the final rise.
REQ-031 Test: in GRID_RUN, drive grid_x=90, grid_y=40, colour=111, plot=1 -> vga_x=90, vga_y=40, vga_colour=111, vga_plot=1 one cycle later.
REQ-032 Test: rst pulse at clear pixel (2,1) -> all outputs 0 asynchronously; with start=0 afterward, no further plots.
REQ-033 Test: start in FIN -> done=0 next cycle, clear restarts at (0,0).
REQ-034 Test: start pulses during CLEAR and GRID_RUN -> no counter reset, pixel sequence unchanged.
